// File: rtl/fft_ctrl_pkg.sv
// Shared encodings and defaults for the FFT frame control path.
package fft_ctrl_pkg;

    localparam int FRAME_LEN_DEF = 4096;
    localparam int ADDR_W_DEF    = 12;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_VSYNC  = 2'd1,
        MODE_FREE   = 2'd2,
        MODE_SINGLE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_FEED   = 2'd3
    } state_e;

    // Qualified trigger sources, one bit per origin.
    typedef struct packed {
        logic vsync;
        logic hop;
        logic single;
    } trig_src_t;

endpackage

// File: rtl/frame_watchdog.sv
// Progress watchdog: counts enabled cycles without a kick and pulses
// timeout once TIMEOUT such cycles have elapsed.
module frame_watchdog #(
    parameter int TIMEOUT = 32768
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;
    logic          at_limit;

    assign at_limit = (cnt == CW'(TIMEOUT - 1));
    assign timeout  = enable & ~kick & at_limit;

    // Idle or kicked -> restart; otherwise count, wrapping after the pulse.
    always_ff @(posedge clk) begin
        if (reset || !enable || kick || at_limit)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Decides when a frame is launched from the sample BRAM into the FFT
// pipeline; tracks frames in flight, dropped triggers and error conditions.
module fft_frame_scheduler
    import fft_ctrl_pkg::*;
#(
    parameter int FRAME_LEN    = FRAME_LEN_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int MAX_INFLIGHT = 2,
    parameter int TIMEOUT      = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] hop,
    input  logic              sample_tick,
    input  logic [ADDR_W-1:0] head,
    input  logic              vsync_pulse,
    input  logic              single_req,
    input  logic              feeder_done,
    input  logic              mag_tvalid,
    input  logic              mag_tlast,
    input  logic              last_missing,
    input  logic              clear_err,
    output logic              start,
    output logic [ADDR_W-1:0] start_addr,
    output logic [1:0]        inflight,
    output logic [7:0]        drop_count,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] fill_cnt, hop_cnt, hop_eff;
    trig_src_t        trig;
    logic             trig_any, fill_full, pending, launch, retire;
    logic             underflow, wd_timeout, eligible, pend_busy, drop_inc;

    assign hop_eff   = (hop == '0) ? CNT_W'(FRAME_LEN) : CNT_W'(hop);
    assign fill_full = (fill_cnt == CNT_W'(FRAME_LEN));

    assign trig.vsync  = (mode == MODE_VSYNC)  & vsync_pulse;
    assign trig.single = (mode == MODE_SINGLE) & single_req;
    assign trig.hop    = (mode == MODE_FREE)   & (hop_cnt >= hop_eff);
    assign trig_any    = |trig;

    assign launch    = (state == ST_LAUNCH);
    assign retire    = mag_tvalid & mag_tlast;
    // A retire alongside a launch pairs with it, so only a lone one underflows.
    assign underflow = retire & (inflight == '0) & ~launch;
    // Pending is being consumed in LAUNCH, so a new trigger there is not a drop.
    assign pend_busy = pending & ~launch;
    assign drop_inc  = trig_any & pend_busy;
    assign eligible  = pending & fill_full & (inflight < 2'(MAX_INFLIGHT)) &
                       (state == ST_ARMED);

    frame_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .enable  ((inflight != '0) || (state == ST_FEED)),
        .kick    (mag_tvalid | feeder_done),
        .timeout (wd_timeout)
    );

    // Warm-up fill level, saturating at one full frame.
    always_ff @(posedge clk) begin
        if (reset)
            fill_cnt <= '0;
        else if (sample_tick && !fill_full)
            fill_cnt <= fill_cnt + 1'b1;
    end

    // Samples since the last hop trigger or launch; a coincident tick counts.
    always_ff @(posedge clk) begin
        if (reset)
            hop_cnt <= '0;
        else if (launch || trig.hop)
            hop_cnt <= sample_tick ? CNT_W'(1) : '0;
        else if (sample_tick && hop_cnt != '1)
            hop_cnt <= hop_cnt + 1'b1;
    end

    // Next-state and decoded outputs; watchdog timeout overrides everything.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = (state != ST_IDLE);
        unique case (state)
            ST_IDLE:   if (mode != MODE_OFF) state_nxt = ST_ARMED;
            ST_ARMED:  if (mode == MODE_OFF) state_nxt = ST_IDLE;
                       else if (eligible)    state_nxt = ST_LAUNCH;
            ST_LAUNCH: begin
                start     = 1'b1;
                state_nxt = ST_FEED;
            end
            ST_FEED:   if (feeder_done)      state_nxt = ST_ARMED;
            default:   state_nxt = ST_IDLE;
        endcase
        if (wd_timeout)
            state_nxt = (mode == MODE_OFF) ? ST_IDLE : ST_ARMED;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Head snapshot taken on entry to LAUNCH so it is valid alongside start.
    always_ff @(posedge clk) begin
        if (reset)
            start_addr <= '0;
        else if (state == ST_ARMED && state_nxt == ST_LAUNCH)
            start_addr <= head;
    end

    // Pending trigger: set wins; consumed by launch or by switching off.
    always_ff @(posedge clk) begin
        if (reset)
            pending <= 1'b0;
        else if (trig_any)
            pending <= 1'b1;
        else if (launch || (mode == MODE_OFF && (state == ST_ARMED || wd_timeout)))
            pending <= 1'b0;
    end

    // Frames in flight: launch adds, retire removes, timeout forgets all.
    always_ff @(posedge clk) begin
        if (reset || wd_timeout)
            inflight <= '0;
        else if (launch && !retire)
            inflight <= inflight + 1'b1;
        else if (retire && !launch && inflight != '0)
            inflight <= inflight - 1'b1;
    end

    // Sticky error; a new error in the clear cycle keeps it set.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (last_missing || wd_timeout || underflow)
            err <= 1'b1;
        else if (clear_err)
            err <= 1'b0;
    end

    // Saturating dropped-trigger count; a drop in the clear cycle beats the clear.
    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (drop_inc) begin
            if (drop_count != 8'hFF)
                drop_count <= drop_count + 1'b1;
        end else if (clear_err)
            drop_count <= '0;
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler: expected launch addresses are
// queued with each trigger and matched against every start pulse.
module tb_fft_frame_scheduler;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic [11:0] hop;
    logic        sample_tick;
    logic [11:0] head;
    logic        vsync_pulse;
    logic        single_req;
    logic        feeder_done;
    logic        mag_tvalid;
    logic        mag_tlast;
    logic        last_missing;
    logic        clear_err;
    logic        start;
    logic [11:0] start_addr;
    logic [1:0]  inflight;
    logic [7:0]  drop_count;
    logic        err;
    logic        busy;

    // Auto-responder and manual drive are OR-ed so each net has one driver.
    logic fd_a, fd_m, mv_a, mv_m;
    logic fdr_auto, ret_auto;
    assign feeder_done = fd_a | fd_m;
    assign mag_tvalid  = mv_a | mv_m;
    assign mag_tlast   = mv_a | mv_m;

    int          n_chk, n_err, n_starts, exp_starts, lim;
    logic [11:0] exp_q[$];

    fft_frame_scheduler dut (
        .clk(clk), .reset(reset), .mode(mode), .hop(hop),
        .sample_tick(sample_tick), .head(head), .vsync_pulse(vsync_pulse),
        .single_req(single_req), .feeder_done(feeder_done),
        .mag_tvalid(mag_tvalid), .mag_tlast(mag_tlast),
        .last_missing(last_missing), .clear_err(clear_err), .start(start),
        .start_addr(start_addr), .inflight(inflight), .drop_count(drop_count),
        .err(err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_start(input logic [11:0] a);
        exp_q.push_back(a);
        exp_starts++;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        head = head + 12'd1;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick();
            if (gap > 1) cyc(gap - 1);
        end
    endtask

    task automatic pulse_vsync();
        vsync_pulse = 1'b1; cyc(1); vsync_pulse = 1'b0;
    endtask

    task automatic pulse_single();
        single_req = 1'b1; cyc(1); single_req = 1'b0;
    endtask

    task automatic retire_m();
        mv_m = 1'b1; cyc(1); mv_m = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_err = 1'b1; cyc(1); clear_err = 1'b0;
    endtask

    // Scoreboard: every start must match the oldest queued address.
    always @(negedge clk) begin
        if (start) begin
            n_starts++;
            if (exp_q.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
            else                   chk("start_addr", 32'(start_addr), 32'(exp_q.pop_front()));
        end
    end

    // Feeder/FFT model: feeder_done 10 cycles after start, retire 5 later.
    initial begin
        fd_a = 1'b0;
        mv_a = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (start && fdr_auto) begin
                cyc(10); fd_a = 1'b1; cyc(1); fd_a = 1'b0;
                if (ret_auto) begin
                    cyc(5); mv_a = 1'b1; cyc(1); mv_a = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_chk = 0; n_err = 0; n_starts = 0; exp_starts = 0;
        reset = 1'b1; mode = 2'd0; hop = '0; sample_tick = 1'b0; head = '0;
        vsync_pulse = 1'b0; single_req = 1'b0; fd_m = 1'b0; mv_m = 1'b0;
        last_missing = 1'b0; clear_err = 1'b0; fdr_auto = 1'b0; ret_auto = 1'b0;
        cyc(3);
        chk("rst_start", start, 0);
        chk("rst_addr", start_addr, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);

        // Warm-up gating: trigger held until the frame buffer is full.
        reset = 1'b0; fdr_auto = 1'b1; ret_auto = 1'b1; mode = 2'd1;
        cyc(2);
        chk("t1_busy", busy, 1);
        ticks(100, 1);
        pulse_vsync();
        cyc(10);
        chk("t1_gated", n_starts, 0);
        expect_start(12'h000);
        ticks(3996, 1);
        cyc(40);
        chk("t1_starts", n_starts, exp_starts);
        chk("t1_inflight", inflight, 0);

        // Free-run hop of 1024 samples, start_addr wraps C00 -> 000.
        mode = 2'd2; hop = 12'd1024;
        expect_start(12'h400); expect_start(12'h800);
        expect_start(12'hC00); expect_start(12'h000);
        ticks(4096, 4);
        cyc(40);
        chk("t2_starts", n_starts, exp_starts);
        chk("t2_drop", drop_count, 0);
        chk("t2_err", err, 0);
        mode = 2'd0;
        cyc(3);
        chk("t2_off_busy", busy, 0);

        // In-flight limit, launch latency, drops.
        mode = 2'd1; ret_auto = 1'b0;
        cyc(2);
        expect_start(head);
        pulse_vsync();
        chk("t3_lat_t1", start, 0);
        cyc(1);
        chk("t3_lat_t2", start, 1);
        cyc(20);
        expect_start(head);
        pulse_vsync();
        cyc(20);
        chk("t3_inflight2", inflight, 2);
        pulse_vsync();
        cyc(20);
        chk("t3_held", n_starts, exp_starts);
        pulse_vsync();
        cyc(2);
        chk("t3_drop", drop_count, 1);
        expect_start(head);
        retire_m();
        chk("t3_retire", inflight, 1);
        cyc(3);
        chk("t3_relaunch", inflight, 2);
        cyc(20);

        // Launch and retire in the same cycle; underflow; clears.
        retire_m();
        chk("t4_pre", inflight, 1);
        expect_start(head);
        pulse_vsync();
        cyc(1);
        chk("t4_in_launch", start, 1);
        retire_m();
        chk("t4_same_cycle", inflight, 1);
        cyc(20);
        retire_m();
        chk("t4_to_zero", inflight, 0);
        chk("t4_no_err", err, 0);
        retire_m();
        chk("t4_under_err", err, 1);
        chk("t4_under_inflight", inflight, 0);
        clear_pulse();
        chk("t4_clr_err", err, 0);
        chk("t4_clr_drop", drop_count, 0);
        last_missing = 1'b1; cyc(1); last_missing = 1'b0;
        chk("t4_last_missing", err, 1);
        clear_pulse();
        chk("t4_clr_err2", err, 0);

        // Watchdog: feeder never finishes.
        fdr_auto = 1'b0; ret_auto = 1'b0;
        expect_start(head);
        pulse_vsync();
        cyc(3);
        chk("t5_inflight", inflight, 1);
        cyc(32000);
        chk("t5_not_early", err, 0);
        lim = 0;
        while (!err && lim < 2000) begin
            cyc(1);
            lim++;
        end
        chk("t5_wd_err", err, 1);
        chk("t5_wd_inflight", inflight, 0);
        chk("t5_wd_busy", busy, 1);
        fdr_auto = 1'b1; ret_auto = 1'b1;
        expect_start(head);
        pulse_vsync();
        cyc(40);
        chk("t5_rearm", n_starts, exp_starts);
        clear_pulse();
        chk("t5_clr_err", err, 0);
        chk("t5_clr_drop", drop_count, 0);

        // Single-shot, then reset while in FEED.
        mode = 2'd3;
        cyc(2);
        pulse_vsync();
        cyc(5);
        chk("t6_vsync_ignored", n_starts, exp_starts);
        expect_start(head);
        pulse_single();
        cyc(40);
        chk("t6_one_start", n_starts, exp_starts);
        expect_start(head);
        pulse_single();
        cyc(2);
        chk("t6_feed_inflight", inflight, 1);
        reset = 1'b1;
        cyc(1);
        chk("t6_rst_start", start, 0);
        chk("t6_rst_inflight", inflight, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_addr", start_addr, 0);
        reset = 1'b0;
        cyc(30);
        chk("t6_stray_err", err, 1);
        chk("t6_stray_inflight", inflight, 0);
        pulse_single();
        cyc(10);
        chk("t6_fill_reset", n_starts, exp_starts);

        chk("sb_empty", exp_q.size(), 0);
        chk("start_total", n_starts, exp_starts);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Decides when a 4096-sample frame is launched from the circular sample frame BRAM into the streaming FFT/magnitude pipeline.
- Sits in the 104 MHz domain:
  - between the trigger sources (synchronized vsync pulse, free-run hop counting on oversample ticks, single-shot button) and the BRAM-to-FFT feeder;
  - tracks frames in flight via magnitude tlast, plus overrun and error conditions.
- Replaces the hard-wired vsync start.

Parameters:
- FRAME_LEN, 4096, samples per FFT frame; also the warm-up fill requirement.
- ADDR_W, 12, frame BRAM address width.
- MAX_INFLIGHT, 2, maximum frames launched but not yet retired.
- TIMEOUT, 32768, cycles without progress before the watchdog fires.

Ports:
- clk  in  1  single clock (104 MHz domain); all logic on posedge.
- reset  in  1  synchronous, active-high.
- mode  in  2  0 = off, 1 = vsync, 2 = free-run, 3 = single-shot.
- hop  in  ADDR_W  free-run samples between launches; 0 means FRAME_LEN.
- sample_tick  in  1  one-cycle pulse per new sample written (fhead advance).
- head  in  ADDR_W  current frame write pointer.
- vsync_pulse  in  1  one-cycle trigger, mode 1.
- single_req  in  1  one-cycle trigger, mode 3.
- feeder_done  in  1  pulse: feeder has sent the last sample of the current frame.
- mag_tvalid  in  1  FFT magnitude output valid.
- mag_tlast  in  1  FFT magnitude last index of frame.
- last_missing  in  1  FFT tlast-missing event.
- clear_err  in  1  pulse: clears the sticky flags and drop_count.
- start  out  1  one-cycle launch pulse to the feeder.
- start_addr  out  ADDR_W  head snapshot at launch (oldest sample of the frame).
- inflight  out  2  frames launched and not yet retired.
- drop_count  out  8  saturating count of dropped triggers.
- err  out  1  sticky: last_missing, watchdog, or retire underflow.
- busy  out  1  high whenever state != IDLE.

Behaviour:
Reset:
- All outputs 0, state IDLE, fill counter 0, hop counter 0, pending 0.

Fill counter:
- Increments on sample_tick, saturates at FRAME_LEN.
- Frames are never launched before the counter saturates.

Hop counter:
- Increments on sample_tick.
- In mode 2, reaching the effective hop raises a trigger and reloads the counter to 0.
- A launch also resets it to 0.
- A tick in the same cycle as the reload counts as 1.

Trigger sources:
- vsync_pulse counts only in mode 1, single_req only in mode 3, the hop trigger only in mode 2.
- A trigger sets pending.
- A trigger arriving while pending is already 1 increments drop_count (saturates at 255).

Eligible when all hold:
- pending = 1;
- fill counter saturated;
- inflight < MAX_INFLIGHT;
- state = ARMED.

FSM:
- IDLE: mode != 0 -> ARMED.
- ARMED:
  - mode = 0 -> IDLE, pending cleared.
  - Eligible -> LAUNCH.
- LAUNCH: lasts one cycle.
  - start = 1; start_addr = head registered this cycle.
  - pending cleared; inflight incremented.
  - -> FEED.
- FEED: waits for feeder_done, then -> ARMED. A mode change here waits until feeder_done.

Latency:
- A trigger in cycle t with everything else eligible gives start = 1 at t+2: pending registered at t+1, LAUNCH state at t+2.

Retire:
- mag_tvalid & mag_tlast decrements inflight.
- Launch and retire in the same cycle leave inflight unchanged.
- A retire with inflight = 0 is ignored and sets err.

Errors and watchdog:
- last_missing sets err; no other effect.
- Watchdog counter is active when inflight > 0 or state = FEED.
  - It resets on any mag_tvalid or feeder_done.
  - Reaching TIMEOUT sets err, forces inflight to 0, and forces state to ARMED (IDLE if mode = 0).
- clear_err clears err and drop_count; a set in the same cycle wins over the clear.

Wrap-around:
- start_addr is head as-is; frame addresses wrap modulo 2^ADDR_W in the feeder.

Reset mid-frame:
- Everything returns to reset values; in-flight frames are forgotten.
- A subsequent stray mag_tlast sets err via the underflow rule.

Decomposition:
- Shared package fft_ctrl_pkg holds:
  - mode encodings MODE_OFF / MODE_VSYNC / MODE_FREE / MODE_SINGLE;
  - state encodings;
  - FRAME_LEN and ADDR_W defaults.
- One natural sub-module: frame_watchdog (progress counter with kick, enable and timeout pulse).
- Everything else lives in the top.

Test Plan:
1. Warm-up gating: mode = 1, vsync_pulse after 100 sample_ticks -> no start. After 4096 ticks the pending trigger launches: start at the cycle after state ARMED with eligibility, start_addr = head (e.g. 12'h000 after exactly 4096 ticks).
2. Free-run hop: mode = 2, hop = 1024, FIFO warm, feeder_done returned 10 cycles after each start, retires prompt -> one start every 1024 ticks; start_addr advances by 0x400 each launch, wrapping 0xC00 -> 0x000.
3. In-flight limit and drops: mode = 1, no mag_tlast, three vsync_pulses each after feeder_done -> inflight = 2, third trigger stays pending. A fourth vsync gives drop_count = 1. One mag_tvalid & mag_tlast -> inflight = 1 and the pending frame launches (inflight = 2).
4. Simultaneous launch/retire: inflight = 1, retire in the LAUNCH cycle -> inflight stays 1. A retire at inflight = 0 -> err = 1, inflight = 0.
5. Watchdog: launch, then never assert feeder_done -> after TIMEOUT cycles err = 1, inflight = 0, state ARMED. clear_err -> err = 0, drop_count = 0.
6. Single-shot and reset mid-FEED: mode = 3, single_req -> exactly one start. Reset asserted in FEED -> next cycle all outputs 0, state IDLE, fill counter 0.
